// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencing controller.
// Holds stall-vector constants, excepttype codes, redirect vectors, the FSM
// state encoding and the redirect-target helper.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned CNT_W   = 6;

  // Redirect vectors
  localparam logic [XLEN-1:0] INT_VECTOR = 32'h0000_0020;
  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0040;
  localparam logic [XLEN-1:0] NEW_PC_RST = 32'h0000_0000;

  // Stall vectors: bit0 PC, bit1 IF/ID, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

  // excepttype codes
  localparam logic [XLEN-1:0] EXC_NONE         = 32'h0;
  localparam logic [XLEN-1:0] EXC_INT          = 32'h1;
  localparam logic [XLEN-1:0] EXC_SYSCALL      = 32'h8;
  localparam logic [XLEN-1:0] EXC_INST_INVALID = 32'ha;
  localparam logic [XLEN-1:0] EXC_OV           = 32'hc;
  localparam logic [XLEN-1:0] EXC_TRAP         = 32'hd;
  localparam logic [XLEN-1:0] EXC_ERET         = 32'he;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  // Redirect target for a nonzero exception code
  function automatic logic [XLEN-1:0] redirect_pc(input logic [XLEN-1:0] code,
                                                  input logic [XLEN-1:0] epc);
    logic [XLEN-1:0] pc;
    case (code)
      EXC_INT:          pc = INT_VECTOR;
      EXC_ERET:         pc = epc;
      EXC_SYSCALL,
      EXC_INST_INVALID,
      EXC_OV,
      EXC_TRAP:         pc = EXC_VECTOR;
      default:          pc = EXC_VECTOR;
    endcase
    return pc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_mc_cnt.sv
// pipe_ctrl_mc_cnt: load/hold/decrement counter for multi-cycle EX ops.
// Ports: clk, rst (async active-low), clr (clear), load/load_val (start
// value), dec (decrement enable), zero_c (combinational strobe: this
// decrement takes the count from 1 to 0).
module pipe_ctrl_mc_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority over load; decrement saturates at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = dec && (cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
// Arbitrates stall requests into a per-stage stall vector, tracks multi-cycle
// EX ops and runs the one-cycle exception flush with redirect.
// Ports: clk, rst (async active-low), stallreq_from_{if,id,mem},
// ex_mc_start/ex_mc_len (multi-cycle op), excepttype, cp0_epc;
// stall (combinational), flush, new_pc, ex_mc_done, ex_mc_abort (registered).
// Build option: PIPE_CTRL_MC_EN enables multi-cycle tracking (MC_BUSY and
// counter); without it ex_mc_start/ex_mc_len are ignored and the pulses are 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_if,
  input  logic               stallreq_from_id,
  input  logic               stallreq_from_mem,
  input  logic               ex_mc_start,
  input  logic [CNT_W-1:0]   ex_mc_len,
  input  logic [XLEN-1:0]    excepttype,
  input  logic [XLEN-1:0]    cp0_epc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [XLEN-1:0]    new_pc,
  output logic               ex_mc_done,
  output logic               ex_mc_abort
);

  state_e          state, state_nxt;
  logic            exc_pend;
  logic            flush_nxt, done_nxt, abort_nxt;
  logic [XLEN-1:0] new_pc_nxt;
  logic            mc_start, mc_long, mc_zero;

  // FLUSH clears the stage holding the exception, so its code is ignored there
  assign exc_pend = (excepttype != EXC_NONE) && (state != FLUSH);

`ifdef PIPE_CTRL_MC_EN
  logic mc_load, mc_dec, mc_clr;

  assign mc_start = ex_mc_start;
  assign mc_long  = ex_mc_len > CNT_W'(1);
  assign mc_load  = (state == RUN) && !exc_pend && ex_mc_start && mc_long;
  assign mc_dec   = (state == MC_BUSY) && !exc_pend && !stallreq_from_mem;
  assign mc_clr   = (state == MC_BUSY) && exc_pend;

  pipe_ctrl_mc_cnt u_mc_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (mc_clr),
    .load     (mc_load),
    .load_val (ex_mc_len - CNT_W'(1)),
    .dec      (mc_dec),
    .zero_c   (mc_zero)
  );
`else
  logic unused_mc;

  assign mc_start  = 1'b0;
  assign mc_long   = 1'b0;
  assign mc_zero   = 1'b0;
  assign unused_mc = ^{ex_mc_start, ex_mc_len};
`endif

  // Stall arbitration; the flush cycle and reset never hold the pipe
  always_comb begin
    stall = STALL_NONE;
    if (!rst || (state == FLUSH)) begin
      stall = STALL_NONE;
    end else if (exc_pend) begin
      stall = STALL_ALL;
    end else if (stallreq_from_mem) begin
      stall = STALL_MEM;
    end else if ((state == MC_BUSY) || mc_start) begin
      stall = STALL_EX;
    end else if (stallreq_from_id) begin
      stall = STALL_ID;
    end else if (stallreq_from_if) begin
      stall = STALL_IF;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nxt  = state;
    flush_nxt  = 1'b0;
    done_nxt   = 1'b0;
    abort_nxt  = 1'b0;
    new_pc_nxt = new_pc;
    case (state)
      RUN: begin
        if (exc_pend) begin
          state_nxt  = FLUSH;
          flush_nxt  = 1'b1;
          new_pc_nxt = redirect_pc(excepttype, cp0_epc);
        end else if (mc_start) begin
          // Length 0 or 1 completes without leaving RUN
          if (mc_long) state_nxt = MC_BUSY;
          else         done_nxt  = 1'b1;
        end
      end
      MC_BUSY: begin
        if (exc_pend) begin
          state_nxt  = FLUSH;
          flush_nxt  = 1'b1;
          abort_nxt  = 1'b1;
          new_pc_nxt = redirect_pc(excepttype, cp0_epc);
        end else if (mc_zero) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
        end
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      flush       <= 1'b0;
      new_pc      <= NEW_PC_RST;
      ex_mc_done  <= 1'b0;
      ex_mc_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      flush       <= flush_nxt;
      new_pc      <= new_pc_nxt;
      ex_mc_done  <= done_nxt;
      ex_mc_abort <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a
// behavioural model of the controller's timing rules.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_MC_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stallreq_from_if, stallreq_from_id, stallreq_from_mem;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_len;
  logic [31:0] excepttype, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_done, ex_mc_abort;

  pipe_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_mem (stallreq_from_mem),
    .ex_mc_start       (ex_mc_start),
    .ex_mc_len         (ex_mc_len),
    .excepttype        (excepttype),
    .cp0_epc           (cp0_epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .ex_mc_done        (ex_mc_done),
    .ex_mc_abort       (ex_mc_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // Reference model: what the outputs should be in the current cycle
  bit          m_flush;   // this cycle is the flush cycle
  logic [31:0] m_pc;
  bit          m_done, m_abort;
  int          m_left;    // busy cycles left in the running multi-cycle op

  logic [5:0]  obs_stall;
  logic        obs_flush, obs_done, obs_abort;
  logic [31:0] obs_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flush = 1'b0; m_pc = 32'h0; m_done = 1'b0; m_abort = 1'b0; m_left = 0;
  endtask

  function automatic logic [5:0] model_stall();
    if (!rst || m_flush)           return 6'b000000;
    if (excepttype != 32'h0)       return 6'b111111;
    if (stallreq_from_mem)         return 6'b011111;
    if (m_left > 0 || (MC_EN && ex_mc_start)) return 6'b001111;
    if (stallreq_from_id)          return 6'b000111;
    if (stallreq_from_if)          return 6'b000011;
    return 6'b000000;
  endfunction

  // Advance the model across the coming clock edge
  task automatic model_step();
    bit exc_p, n_done, n_abort;
    exc_p   = (excepttype != 32'h0) && !m_flush;
    n_done  = 1'b0;
    n_abort = 1'b0;
    if (exc_p) begin
      m_pc    = (excepttype == 32'h1) ? 32'h20 : (excepttype == 32'he) ? cp0_epc : 32'h40;
      n_abort = (m_left > 0);
      m_left  = 0;
    end else if (m_left > 0) begin
      if (!stallreq_from_mem) begin
        m_left--;
        n_done = (m_left == 0);
      end
    end else if (!m_flush && MC_EN && ex_mc_start) begin
      if (ex_mc_len <= 6'd1) n_done = 1'b1;
      else                   m_left = int'(ex_mc_len) - 1;
    end
    m_flush = exc_p;
    m_done  = n_done;
    m_abort = n_abort;
  endtask

  // One clock cycle: drive inputs, observe, check against the model, advance it
  task automatic cyc(input bit i_mem, input bit i_id, input bit i_if, input bit i_start,
                     input logic [5:0] i_len, input logic [31:0] i_exc, input logic [31:0] i_epc);
    @(negedge clk);
    cyc_n++;
    stallreq_from_mem = i_mem;
    stallreq_from_id  = i_id;
    stallreq_from_if  = i_if;
    ex_mc_start       = i_start;
    ex_mc_len         = i_len;
    excepttype        = i_exc;
    cp0_epc           = i_epc;
    #1;
    obs_stall = stall;
    obs_flush = flush;
    obs_pc    = new_pc;
    obs_done  = ex_mc_done;
    obs_abort = ex_mc_abort;
    chk("m_stall", 32'(obs_stall), 32'(model_stall()));
    chk("m_flush", 32'(obs_flush), 32'(m_flush));
    chk("m_new_pc", obs_pc, m_pc);
    chk("m_done", 32'(obs_done), 32'(m_done));
    chk("m_abort", 32'(obs_abort), 32'(m_abort));
    model_step();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'h0);
    chk({tag, "_flush"}, 32'(flush), 32'h0);
    chk({tag, "_new_pc"}, new_pc, 32'h0);
    chk({tag, "_done"}, 32'(ex_mc_done), 32'h0);
    chk({tag, "_abort"}, 32'(ex_mc_abort), 32'h0);
  endtask

  initial begin
    int lat;
    int n_flush;
    bit any_done;
    rst = 1'b0;
    stallreq_from_if = 1'b0; stallreq_from_id = 1'b0; stallreq_from_mem = 1'b0;
    ex_mc_start = 1'b0; ex_mc_len = 6'd0; excepttype = 32'h0; cp0_epc = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Stall priority
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0, 32'h0);
    chk("id_if", 32'(obs_stall), 32'h07);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0, 32'h0);
    chk("mem_id_if", 32'(obs_stall), 32'h1f);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 32'h0);
    chk("if_only", 32'(obs_stall), 32'h03);

    // Multi-cycle op of length 4
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 32'h0, 32'h0);
    chk("mc4_start", 32'(obs_stall), MC_EN ? 32'h0f : 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("mc4_busy", 32'(obs_stall), MC_EN ? 32'h0f : 32'h0);
      chk("mc4_nodone", 32'(obs_done), 32'h0);
    end
    idle();
    chk("mc4_done", 32'(obs_done), 32'(MC_EN));
    chk("mc4_release", 32'(obs_stall), 32'h0);
    idle();
    chk("mc4_pulse", 32'(obs_done), 32'h0);

    // Length 0 behaves as length 1
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 32'h0, 32'h0);
    idle();
    chk("mc0_done", 32'(obs_done), 32'(MC_EN));
    chk("mc0_stall", 32'(obs_stall), 32'h0);

`ifdef PIPE_CTRL_MC_EN
    // Length 5 with MEM stall in op cycles 2 and 3: done two cycles late
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 32'h0, 32'h0);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      cyc(k == 1 || k == 2, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
      if (obs_done) lat = k;
    end
    chk("mc5_memstall_latency", 32'(lat), 32'd7);

    // Exception during MC_BUSY aborts the op
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd6, 32'h0, 32'h0);
    idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'hc, 32'h0);
    chk("abort_exc_stall", 32'(obs_stall), 32'h3f);
    idle();
    chk("abort_pulse", 32'(obs_abort), 32'h1);
    chk("abort_flush", 32'(obs_flush), 32'h1);
    any_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idle();
      any_done |= obs_done;
    end
    chk("abort_no_done", 32'(any_done), 32'h0);
`endif

    // Syscall: stall, flush to EXC_VECTOR, resume
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h8, 32'h0);
    chk("sys_stall", 32'(obs_stall), 32'h3f);
    idle();
    chk("sys_flush", 32'(obs_flush), 32'h1);
    chk("sys_new_pc", obs_pc, 32'h40);
    chk("sys_flush_stall", 32'(obs_stall), 32'h0);
    idle();
    chk("sys_resume", 32'(obs_stall), 32'h0);
    chk("sys_flush_end", 32'(obs_flush), 32'h0);

    // Interrupt
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h1, 32'h0);
    idle();
    chk("int_new_pc", obs_pc, 32'h20);

    // eret held through the flush cycle: one flush only
    n_flush = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'he, 32'h1234);
    n_flush += int'(obs_flush);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'he, 32'h1234);
    n_flush += int'(obs_flush);
    chk("eret_new_pc", obs_pc, 32'h1234);
    chk("eret_flush_stall", 32'(obs_stall), 32'h0);
    idle();
    n_flush += int'(obs_flush);
    idle();
    n_flush += int'(obs_flush);
    chk("eret_one_flush", 32'(n_flush), 32'd1);

    // Reset asserted in the middle of a multi-cycle op
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6'd6, 32'h0, 32'h0);
    idle();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("midop_rst");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle();
    idle();
    chk("post_rst_done", 32'(obs_done), 32'h0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [31:0] e;
      case ($urandom_range(0, 24))
        0:       e = 32'h1;
        1:       e = 32'h8;
        2:       e = 32'ha;
        3:       e = 32'hc;
        4:       e = 32'hd;
        5:       e = 32'he;
        default: e = 32'h0;
      endcase
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 5) == 0, 6'($urandom_range(0, 9)), e, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
